// File: rtl/ddr_pkg.sv
// Shared definitions for the falling-arrow playfield controller.
//   state_e   : round state encoding (also driven on the scheduler's state port)
//   NUM_LANES : number of arrow lanes
//   LFSR_*    : spawn LFSR seed, tap mask and step function
package ddr_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StCountdown = 2'd1,
    StPlaying   = 2'd2,
    StOver      = 2'd3
  } state_e;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = $clog2(NUM_LANES);

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 (1-based) map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lane_picker.sv
// Rotating find-first-free lane selector (purely combinational).
//   start_idx_i : lane checked first; the search wraps upward modulo NUM_LANES
//   busy_i      : per-lane occupied flags
//   grant_o     : one-hot first free lane at or after start_idx_i
//   valid_o     : a free lane was found
module lane_picker
  import ddr_pkg::*;
(
  input  logic [LANE_W-1:0]    start_idx_i,
  input  logic [NUM_LANES-1:0] busy_i,
  output logic [NUM_LANES-1:0] grant_o,
  output logic                 valid_o
);

  logic [LANE_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      idx = LANE_W'(32'(start_idx_i) + k);
      if (!valid_o && !busy_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Round sequencer and arrow spawn scheduler for the falling-arrow playfield.
//   CLK, reset     : clock and asynchronous active-high reset
//   hc, vc         : raster position; (0,0) marks the once-per-frame tick
//   start          : level-sensitive start request, sampled on frame ticks
//   hit, miss      : one-cycle judge pulses, counted on any cycle while playing
//   lane_busy      : lanes that still hold an arrow above the spawn zone
//   spawn          : one-hot, one-cycle spawn pulse
//   y_speed        : fall speed in pixels per frame
//   level          : difficulty level (0..15)
//   state          : 0 idle, 1 countdown, 2 playing, 3 over
module note_scheduler
  import ddr_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned GAP_INIT         = 60,
  parameter int unsigned GAP_STEP         = 5,
  parameter int unsigned GAP_MIN          = 15,
  parameter int unsigned SPEED_INIT       = 1,
  parameter int unsigned SPEED_MAX        = 8,
  parameter int unsigned HITS_PER_LEVEL   = 8,
  parameter int unsigned MISS_LIMIT       = 10
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [9:0]           hc,
  input  logic [9:0]           vc,
  input  logic                 start,
  input  logic                 hit,
  input  logic                 miss,
  input  logic [NUM_LANES-1:0] lane_busy,
  output logic [NUM_LANES-1:0] spawn,
  output logic [7:0]           y_speed,
  output logic [3:0]           level,
  output logic [1:0]           state
);

  localparam logic [15:0] CdLast    = 16'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0]  HitWrap   = 8'(HITS_PER_LEVEL - 1);
  localparam logic [7:0]  MissLimit = 8'(MISS_LIMIT);
  localparam logic [7:0]  GapInit   = 8'(GAP_INIT);
  localparam logic [8:0]  SpeedInit = 9'(SPEED_INIT);
  localparam logic [8:0]  SpeedMax  = 9'(SPEED_MAX);

  state_e                 state_q, state_d;
  logic [15:0]            cd_cnt_q, cd_cnt_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [7:0]             hit_cnt_q, hit_cnt_d;
  logic [7:0]             miss_cnt_q, miss_cnt_d;
  logic [3:0]             level_q, level_d;
  logic [7:0]             lfsr_q, lfsr_d;
  logic [NUM_LANES-1:0]   spawn_q, spawn_d;
  logic [7:0]             y_speed_q, y_speed_d;

  logic                   frame_tick;
  logic signed [8:0]      gap_raw;
  logic [7:0]             gap_cur;
  logic [8:0]             speed_sum;
  logic [NUM_LANES-1:0]   pick_grant;
  logic                   pick_valid;

  assign frame_tick = (hc == 10'd0) && (vc == 10'd0);

  // 9-bit signed so high levels go negative instead of wrapping, then clamp.
  assign gap_raw = $signed(9'(GAP_INIT)) - $signed(9'(GAP_STEP * 32'(level_q)));
  assign gap_cur = (gap_raw < $signed(9'(GAP_MIN))) ? 8'(GAP_MIN) : gap_raw[7:0];

  assign speed_sum = SpeedInit + {5'd0, level_q};

  lane_picker u_lane_picker (
    .start_idx_i (lfsr_q[LANE_W-1:0]),
    .busy_i      (lane_busy),
    .grant_o     (pick_grant),
    .valid_o     (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    cd_cnt_d   = cd_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    level_d    = level_q;
    lfsr_d     = lfsr_q;
    spawn_d    = '0;

    if (frame_tick) begin
      lfsr_d = lfsr_next(lfsr_q);
    end

    // Judge pulses are not tied to the frame tick.
    if (state_q == StPlaying) begin
      if (hit) begin
        if (hit_cnt_q == HitWrap) begin
          hit_cnt_d = '0;
          if (level_q != 4'hF) level_d = level_q + 4'd1;
        end else begin
          hit_cnt_d = hit_cnt_q + 8'd1;
        end
      end
      if (miss && (miss_cnt_q != 8'hFF)) begin
        miss_cnt_d = miss_cnt_q + 8'd1;
      end
    end

    if (frame_tick) begin
      case (state_q)
        StIdle, StOver: begin
          if (start) begin
            state_d    = StCountdown;
            level_d    = '0;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            cd_cnt_d   = '0;
          end
        end
        StCountdown: begin
          if (cd_cnt_q == CdLast) begin
            state_d   = StPlaying;
            gap_cnt_d = GapInit;
          end else begin
            cd_cnt_d = cd_cnt_q + 16'd1;
          end
        end
        StPlaying: begin
          // Registered miss count: a miss on this tick is seen next tick.
          if (miss_cnt_q >= MissLimit) begin
            state_d = StOver;
          end else if (gap_cnt_q > 8'd1) begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end else if (pick_valid) begin
            // The tick that reaches zero also fires, so spawns are exactly
            // 'gap' ticks apart; a count already at zero is a retry.
            spawn_d   = pick_grant;
            gap_cnt_d = gap_cur;
          end else begin
            gap_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    if ((state_q == StCountdown) || (state_q == StPlaying)) begin
      y_speed_d = (speed_sum > SpeedMax) ? SpeedMax[7:0] : speed_sum[7:0];
    end else begin
      y_speed_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cd_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      level_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      spawn_q    <= '0;
      y_speed_q  <= '0;
    end else begin
      state_q    <= state_d;
      cd_cnt_q   <= cd_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      level_q    <= level_d;
      lfsr_q     <= lfsr_d;
      spawn_q    <= spawn_d;
      y_speed_q  <= y_speed_d;
    end
  end

  assign spawn   = spawn_q;
  assign y_speed = y_speed_q;
  assign level   = level_q;
  assign state   = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed self-checking bench for note_scheduler.
module tb_note_scheduler;

  logic       CLK;
  logic       reset;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       start;
  logic       hit;
  logic       miss;
  logic [3:0] lane_busy;
  logic [3:0] spawn;
  logic [7:0] y_speed;
  logic [3:0] level;
  logic [1:0] state;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [7:0]  lfsr_m;   // reference LFSR, mirrors the tap polynomial independently
  logic [1:0]  cand;     // candidate lane used on the most recent tick

  note_scheduler #(
    .COUNTDOWN_FRAMES (3),
    .GAP_INIT         (60),
    .GAP_STEP         (5),
    .GAP_MIN          (15),
    .SPEED_INIT       (1),
    .SPEED_MAX        (8),
    .HITS_PER_LEVEL   (2),
    .MISS_LIMIT       (3)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .hc        (hc),
    .vc        (vc),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .lane_busy (lane_busy),
    .spawn     (spawn),
    .y_speed   (y_speed),
    .level     (level),
    .state     (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference LFSR step: x^8 + x^6 + x^5 + x^4, feedback into bit 0.
  function automatic logic [7:0] ref_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // One frame tick; returns #1 after the tick edge with outputs settled.
  task automatic do_tick();
    @(negedge CLK);
    hc = 10'd0;
    vc = 10'd0;
    cand = lfsr_m[1:0];
    @(posedge CLK);
    #1;
    hc = 10'd1;
    lfsr_m = ref_step(lfsr_m);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic h, input logic m);
    @(negedge CLK);
    hit  = h;
    miss = m;
    @(posedge CLK);
    #1;
    hit  = 1'b0;
    miss = 1'b0;
  endtask

  // Ticks until a spawn appears (bounded); returns ticks taken.
  task automatic ticks_to_spawn(output int n);
    n = 0;
    do begin
      do_tick();
      n++;
    end while ((spawn == 4'd0) && (n < 80));
  endtask

  int          n;
  int unsigned bad;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    hc = 10'd1; vc = 10'd0;
    start = 1'b0; hit = 1'b0; miss = 1'b0;
    lane_busy = 4'h0;
    lfsr_m = 8'hA5;
    cand = 2'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_yspeed", 32'(y_speed), 32'd0);
    chk("rst_spawn", 32'(spawn), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'hA5);

    // Idle holds without start
    bad = 0;
    repeat (5) begin
      do_tick();
      if (state != 2'd0) bad++;
    end
    chk("idle_hold", bad, 0);

    // Countdown: state 1 for exactly 3 ticks
    start = 1'b1;
    do_tick();
    start = 1'b0;
    chk("cd_enter", 32'(state), 32'd1);
    cyc();
    chk("cd_yspeed", 32'(y_speed), 32'd1);
    do_tick();
    chk("cd_t1", 32'(state), 32'd1);
    do_tick();
    chk("cd_t2", 32'(state), 32'd1);
    do_tick();
    chk("cd_play", 32'(state), 32'd2);

    // First spawn exactly GAP_INIT ticks after entering PLAYING
    bad = 0;
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      if (i < 60 && spawn != 4'd0) bad++;
    end
    chk("first_spawn_lane", 32'(spawn), 32'(4'b0001 << cand));
    chk("no_early_spawn", bad, 0);
    cyc();
    chk("spawn_one_cycle", 32'(spawn), 32'd0);

    // Level/speed: 2 hits per level, 1-cycle latency, y_speed one later
    pulse(1'b1, 1'b0);
    chk("lvl_after_1hit", 32'(level), 32'd0);
    pulse(1'b1, 1'b0);
    chk("lvl_after_2hit", 32'(level), 32'd1);
    chk("ys_lag", 32'(y_speed), 32'd1);
    cyc();
    chk("ys_lvl1", 32'(y_speed), 32'd2);
    repeat (18) pulse(1'b1, 1'b0);
    cyc();
    chk("lvl_20hits", 32'(level), 32'd10);
    chk("ys_sat", 32'(y_speed), 32'd8);

    // Counter was reloaded with level-0 gap; next reload uses level-10 gap
    ticks_to_spawn(n);
    chk("gap_lvl0", 32'(n), 32'd60);
    ticks_to_spawn(n);
    chk("gap_lvl10", 32'(n), 32'd15);

    // Simultaneous hit+miss: both count
    pulse(1'b1, 1'b1);
    chk("lvl_hitmiss", 32'(level), 32'd10);
    pulse(1'b1, 1'b0);
    chk("lvl_11", 32'(level), 32'd11);
    pulse(1'b1, 1'b0);   // leaves hit counter at 1

    // Lane skip
    lane_busy = 4'hF;
    bad = 0;
    repeat (20) begin
      do_tick();
      if (spawn != 4'd0) bad++;
    end
    n = 0;
    while (lfsr_m[1:0] != 2'd1 && n < 64) begin
      do_tick();
      if (spawn != 4'd0) bad++;
      n++;
    end
    chk("busy_no_spawn", bad, 0);
    chk("cand1_found", 32'(lfsr_m[1:0]), 32'd1);
    lane_busy = 4'b0111;
    do_tick();
    chk("skip_to_lane3", 32'(spawn), 32'b1000);
    lane_busy = 4'hF;
    bad = 0;
    repeat (18) begin
      do_tick();
      if (spawn != 4'd0) bad++;
    end
    chk("all_busy_retry", bad, 0);
    lane_busy = 4'b1011;
    do_tick();
    chk("retry_lane2", 32'(spawn), 32'b0100);
    lane_busy = 4'h0;
    ticks_to_spawn(n);
    chk("reload_after_retry", 32'(n), 32'd15);
    chk("reload_lane", 32'(spawn), 32'(4'b0001 << cand));

    // Game over: miss count is 1 from the simultaneous pulse
    pulse(1'b0, 1'b1);
    do_tick();
    chk("miss2_still_play", 32'(state), 32'd2);
    pulse(1'b0, 1'b1);
    do_tick();
    chk("over", 32'(state), 32'd3);
    cyc();
    chk("over_yspeed", 32'(y_speed), 32'd0);
    bad = 0;
    repeat (3) begin
      do_tick();
      if (spawn != 4'd0) bad++;
    end
    chk("over_no_spawn", bad, 0);
    chk("over_hold", 32'(state), 32'd3);

    // Restart clears level and counters
    start = 1'b1;
    do_tick();
    start = 1'b0;
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_level", 32'(level), 32'd0);
    cyc();
    chk("restart_yspeed", 32'(y_speed), 32'd1);
    repeat (3) do_tick();
    chk("restart_play", 32'(state), 32'd2);
    do_tick();
    do_tick();
    chk("miss_cleared", 32'(state), 32'd2);
    pulse(1'b1, 1'b0);
    chk("hitcnt_cleared", 32'(level), 32'd0);

    // Reset mid-PLAYING while a spawn pulse is live
    ticks_to_spawn(n);
    chk("pending_spawn", 32'(spawn != 4'd0), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_spawn", 32'(spawn), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_yspeed", 32'(y_speed), 32'd0);
    chk("async_lfsr", 32'(dut.lfsr_q), 32'hA5);
    @(negedge CLK);
    reset = 1'b0;
    lfsr_m = 8'hA5;
    bad = 0;
    repeat (5) begin
      do_tick();
      if (state != 2'd0 || spawn != 4'd0) bad++;
    end
    chk("post_rst_idle", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
